// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen RTL blocks: interrupt aggregator FSM states and source modes.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_IRQ_IDLE,
    RGGEN_IRQ_ACCUM,
    RGGEN_IRQ_FIRE
  } rggen_irq_state;

  localparam logic RGGEN_IRQ_LEVEL = 1'b0;
  localparam logic RGGEN_IRQ_EDGE  = 1'b1;

endpackage

// File: rtl/rggen_irq_coalescer.sv
// Interrupt coalescing FSM: holds off o_fire until enough events accumulate or a timeout expires.
// Compiled only when RGGEN_IRQ_COALESCE_EN is defined.
`ifdef RGGEN_IRQ_COALESCE_EN
module rggen_irq_coalescer
  import rggen_rtl_pkg::*;
#(
  parameter int TOTAL_INTERRUPTS = 8,
  parameter int COALESCE_WIDTH   = 8
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_pending_any,
  input  logic [TOTAL_INTERRUPTS-1:0] i_new_events,
  input  logic [COALESCE_WIDTH-1:0]   i_threshold,
  input  logic [COALESCE_WIDTH-1:0]   i_timeout,
  output logic                        o_fire
);

  localparam int CW = COALESCE_WIDTH;
  localparam int SW = CW + 8;

  rggen_irq_state    state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]     tmr_q, tmr_d, tmr_inc;
  logic [7:0]        evt_num;
  logic [SW-1:0]     cnt_sum;

  always_comb begin
    evt_num = '0;
    for (int i = 0; i < TOTAL_INTERRUPTS; i++) begin
      evt_num = evt_num + 8'(i_new_events[i]);
    end
  end

  // Both counters saturate rather than wrap so a long burst can never re-arm the threshold.
  assign cnt_sum = SW'(cnt_q) + SW'(evt_num);
  assign cnt_inc = (|cnt_sum[SW-1:CW]) ? '1 : cnt_sum[CW-1:0];
  assign tmr_inc = (&tmr_q) ? tmr_q : tmr_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    case (state_q)
      RGGEN_IRQ_IDLE: begin
        if (i_pending_any) begin
          cnt_d   = CW'(1);
          tmr_d   = '0;
          state_d = (i_threshold <= CW'(1)) ? RGGEN_IRQ_FIRE : RGGEN_IRQ_ACCUM;
        end
      end
      RGGEN_IRQ_ACCUM: begin
        if (!i_pending_any) begin
          state_d = RGGEN_IRQ_IDLE;
          cnt_d   = '0;
          tmr_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          tmr_d = tmr_inc;
          if ((cnt_inc >= i_threshold) ||
              ((i_timeout != '0) && (tmr_inc >= i_timeout))) begin
            state_d = RGGEN_IRQ_FIRE;
          end
        end
      end
      RGGEN_IRQ_FIRE: begin
        if (!i_pending_any) begin
          state_d = RGGEN_IRQ_IDLE;
          cnt_d   = '0;
          tmr_d   = '0;
        end
      end
      default: state_d = RGGEN_IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RGGEN_IRQ_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  assign o_fire = (state_q == RGGEN_IRQ_FIRE);

endmodule
`endif

// File: rtl/rggen_irq_aggregator.sv
// Interrupt aggregator: synchronise sources, capture sticky status, mask, and encode the request.
// Optional coalescing is enabled with the RGGEN_IRQ_COALESCE_EN macro.
module rggen_irq_aggregator
  import rggen_rtl_pkg::*;
#(
  parameter int                          TOTAL_INTERRUPTS = 8,
  parameter logic [TOTAL_INTERRUPTS-1:0] SOURCE_MODE      = '0,
  parameter int                          SYNC_STAGES      = 2,
  parameter int                          COALESCE_WIDTH   = 8,
  localparam int ID_WIDTH = (TOTAL_INTERRUPTS > 1) ? $clog2(TOTAL_INTERRUPTS) : 1
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [TOTAL_INTERRUPTS-1:0] i_src,
  input  logic [TOTAL_INTERRUPTS-1:0] i_ier,
  input  logic [TOTAL_INTERRUPTS-1:0] i_clear,
`ifdef RGGEN_IRQ_COALESCE_EN
  input  logic [COALESCE_WIDTH-1:0]   i_coalesce_threshold,
  input  logic [COALESCE_WIDTH-1:0]   i_coalesce_timeout,
`endif
  output logic [TOTAL_INTERRUPTS-1:0] o_isr,
  output logic                        o_irq,
  output logic [ID_WIDTH-1:0]         o_irq_id
);

  localparam int N = TOTAL_INTERRUPTS;

  logic [N-1:0]        src_sync, src_dly_q, edge_mask, src_event;
  logic [N-1:0]        isr_q, isr_d, pending;
  logic [ID_WIDTH-1:0] irq_id_q, irq_id_d;

  if ((N < 1) || (N > 64) || (COALESCE_WIDTH < 1) || (SYNC_STAGES < 0)) begin : g_param_check
    $error("rggen_irq_aggregator: unsupported parameter combination");
  end

  if (SYNC_STAGES == 0) begin : g_nosync
    assign src_sync = i_src;
  end else begin : g_sync
    logic [N-1:0] stage_q [SYNC_STAGES];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= '0;
      end else begin
        stage_q[0] <= i_src;
        for (int s = 1; s < SYNC_STAGES; s++) stage_q[s] <= stage_q[s-1];
      end
    end
    assign src_sync = stage_q[SYNC_STAGES-1];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_mode
    assign edge_mask[gi] = (SOURCE_MODE[gi] == RGGEN_IRQ_EDGE);
  end

  // Level bits see the synced level directly; edge bits need a fresh 0->1 step.
  // A held-high level re-sets status every cycle, which is why clear cannot win there.
  assign src_event = src_sync & ~(src_dly_q & edge_mask);
  assign isr_d     = src_event | (isr_q & ~i_clear);
  assign pending   = isr_q & i_ier;

  always_comb begin
    irq_id_d = irq_id_q;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) irq_id_d = ID_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_dly_q <= '0;
      isr_q     <= '0;
      irq_id_q  <= '0;
    end else begin
      src_dly_q <= src_sync;
      isr_q     <= isr_d;
      irq_id_q  <= irq_id_d;
    end
  end

`ifdef RGGEN_IRQ_COALESCE_EN
  rggen_irq_coalescer #(
    .TOTAL_INTERRUPTS (N),
    .COALESCE_WIDTH   (COALESCE_WIDTH)
  ) u_coalescer (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_pending_any (|pending),
    .i_new_events  (src_event & i_ier),
    .i_threshold   (i_coalesce_threshold),
    .i_timeout     (i_coalesce_timeout),
    .o_fire        (o_irq)
  );
`else
  logic irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= |pending;
  end
  assign o_irq = irq_q;
`endif

  assign o_isr    = isr_q;
  assign o_irq_id = irq_id_q;

endmodule

// File: tb/tb_rggen_irq_aggregator.sv
// Self-checking bench for rggen_irq_aggregator: directed vectors plus a per-cycle reference model.
module tb_rggen_irq_aggregator;

  localparam int            N    = 8;
  localparam int            SYNC = 2;
  localparam int            CW   = 8;
  localparam logic [N-1:0]  MODE = 8'h28;  // sources 3 and 5 are rising-edge

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] i_src, i_ier, i_clear;
  logic [N-1:0] o_isr;
  logic         o_irq;
  logic [2:0]   o_irq_id;
`ifdef RGGEN_IRQ_COALESCE_EN
  logic [CW-1:0] thr, tmo;
`endif

  rggen_irq_aggregator #(
    .TOTAL_INTERRUPTS (N),
    .SOURCE_MODE      (MODE),
    .SYNC_STAGES      (SYNC),
    .COALESCE_WIDTH   (CW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_src                (i_src),
    .i_ier                (i_ier),
    .i_clear              (i_clear),
`ifdef RGGEN_IRQ_COALESCE_EN
    .i_coalesce_threshold (thr),
    .i_coalesce_timeout   (tmo),
`endif
    .o_isr                (o_isr),
    .o_irq                (o_irq),
    .o_irq_id             (o_irq_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: sources seen through a SYNC-deep delay line, status as a sticky set/clear
  // per bit, request and ID derived from the status held before this edge.
  logic [N-1:0] hist [SYNC+2];
  logic [N-1:0] m_isr = '0;
  logic         m_irq = 1'b0;
  logic [2:0]   m_id  = '0;
  bit           chk_en = 1'b0;
  bit           model_irq_en = 1'b1;

  initial begin
    for (int k = 0; k < SYNC + 2; k++) hist[k] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < SYNC + 2; k++) hist[k] = '0;
        m_isr = '0;
        m_irq = 1'b0;
        m_id  = '0;
      end else begin
        logic [N-1:0] pend, evt;
        for (int k = SYNC + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = i_src;
        pend  = m_isr & i_ier;
        m_irq = (pend != '0);
        for (int b = N - 1; b >= 0; b--) if (pend[b]) m_id = 3'(b);
        for (int b = 0; b < N; b++)
          evt[b] = MODE[b] ? (hist[SYNC][b] & ~hist[SYNC+1][b]) : hist[SYNC][b];
        m_isr = evt | (m_isr & ~i_clear);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        check("model_isr", 64'(o_isr), 64'(m_isr));
        check("model_id", 64'(o_irq_id), 64'(m_id));
        if (model_irq_en) check("model_irq", 64'(o_irq), 64'(m_irq));
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    i_src   = '0;
    i_ier   = '0;
    i_clear = '0;
`ifdef RGGEN_IRQ_COALESCE_EN
    thr = CW'(1);
    tmo = '0;
`endif
    tick(3);
    check("reset_isr", 64'(o_isr), 64'h0);
    check("reset_irq", 64'(o_irq), 64'h0);
    check("reset_id", 64'(o_irq_id), 64'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    // 1: edge source 3, latency SYNC+1 to status, +1 to request
    i_ier    = 8'h08;
    i_src[3] = 1'b1;
    tick(2);
    check("t1_isr_early", 64'(o_isr), 64'h00);
    tick();
    check("t1_isr", 64'(o_isr), 64'h08);
    check("t1_irq_early", 64'(o_irq), 64'h0);
    tick();
    check("t1_irq", 64'(o_irq), 64'h1);
    check("t1_id", 64'(o_irq_id), 64'h3);

    // 2: rising edge coinciding with clear -> set wins
    i_src[3] = 1'b0;
    tick(3);
    i_clear = 8'h08; tick(); i_clear = '0;
    check("t2_cleared", 64'(o_isr[3]), 64'h0);
    i_src[3] = 1'b1;
    tick(2);
    i_clear = 8'h08; tick(); i_clear = '0;
    check("t2_set_wins", 64'(o_isr[3]), 64'h1);

    // 3: level source 1 ignores clear while high
    i_ier    = 8'h02;
    i_src[1] = 1'b1;
    tick(3);
    check("t3_isr_set", 64'(o_isr[1]), 64'h1);
    i_clear = 8'h02; tick(); i_clear = '0;
    check("t3_level_hold", 64'(o_isr[1]), 64'h1);
    check("t3_irq_hold", 64'(o_irq), 64'h1);
    i_src[1] = 1'b0;
    tick(2);
    i_clear = 8'h02; tick(); i_clear = '0;
    check("t3_isr_clr", 64'(o_isr[1]), 64'h0);
    check("t3_irq_lag", 64'(o_irq), 64'h1);
    tick();
    check("t3_irq_drop", 64'(o_irq), 64'h0);

    // 4: two simultaneous sources, lowest index wins; ID holds when nothing pends
    i_ier   = 8'hff;
    i_clear = 8'hff; tick(); i_clear = '0;
    i_src   = i_src | 8'h24;
    tick(3);
    check("t4_isr", 64'(o_isr), 64'h24);
    tick();
    check("t4_irq", 64'(o_irq), 64'h1);
    check("t4_id_low", 64'(o_irq_id), 64'h2);
    i_src[2] = 1'b0;
    tick(2);
    i_clear = 8'h04; tick(); i_clear = '0;
    tick();
    check("t4_id_next", 64'(o_irq_id), 64'h5);
    check("t4_irq_stays", 64'(o_irq), 64'h1);
    i_clear = 8'h20; tick(); i_clear = '0;
    tick();
    check("t4_irq_off", 64'(o_irq), 64'h0);
    check("t4_id_hold", 64'(o_irq_id), 64'h5);

`ifdef RGGEN_IRQ_COALESCE_EN
    // 5: threshold of four events on edge source 3
    model_irq_en = 1'b0;
    i_src = '0;
    i_ier = 8'h08;
    tick(3);
    i_clear = 8'hff; tick(); i_clear = '0;
    tick(2);
    thr = CW'(4);
    tmo = '0;
    repeat (3) begin
      i_src[3] = 1'b1; tick(); i_src[3] = 1'b0; tick();
    end
    tick(4);
    check("t5_below_thr", 64'(o_irq), 64'h0);
    i_src[3] = 1'b1; tick(); i_src[3] = 1'b0; tick();
    tick(4);
    check("t5_at_thr", 64'(o_irq), 64'h1);
    i_clear = 8'hff; tick(); i_clear = '0;
    tick();
    check("t5_idle", 64'(o_irq), 64'h0);

    // 6: timeout fires five cycles after ACCUM entry; reset mid-ACCUM
    thr = CW'(10);
    tmo = CW'(5);
    tick(2);
    i_src[3] = 1'b1; tick(); i_src[3] = 1'b0;
    begin
      int n;
      n = 0;
      while (o_isr[3] !== 1'b1 && n < 20) begin tick(); n++; end
      check("t6_isr_seen", 64'(n < 20), 64'h1);
      n = 0;
      while (o_irq !== 1'b1 && n < 20) begin tick(); n++; end
      check("t6_timeout_lat", 64'(n), 64'd6);
    end
    i_clear = 8'hff; tick(); i_clear = '0;
    tick(2);
    i_src[3] = 1'b1; tick(); i_src[3] = 1'b0;
    tick(3);
    check("t6_pre_rst_isr", 64'(o_isr), 64'h08);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_isr", 64'(o_isr), 64'h0);
    check("t6_rst_irq", 64'(o_irq), 64'h0);
    check("t6_rst_id", 64'(o_irq_id), 64'h0);
    tick();
    rst_n = 1'b1;
    tick(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
